// File: rtl/fb_pkg.sv
// Shared frame buffer constants and the write-controller state type.
// Used by the write arbiter, the RAM instantiation and the renderers.
package fb_pkg;

  localparam int FB_AWIDTH = 15;
  localparam int FB_WIDTH  = 3;
  localparam int FB_DEPTH  = 32768;

  localparam logic [FB_WIDTH-1:0] FB_CLEAR_COLOR = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a last-winner pointer.
// Reusable by any two-requester frame buffer client.
module rr_arb2 (
  input  logic Clock_50,
  input  logic Reset_n,
  input  logic Enable,
  input  logic Req0,
  input  logic Req1,
  output logic Gnt0,
  output logic Gnt1
);

  // last_q = 1 means requester 1 won most recently, so requester 0 is favoured
  logic last_q;
  logic last_d;

  always_comb begin
    Gnt0   = Enable & Req0 & (~Req1 | last_q);
    Gnt1   = Enable & Req1 & (~Req0 | ~last_q);
    last_d = last_q;
    if (Gnt0) begin
      last_d = 1'b0;
    end else if (Gnt1) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (!Reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port controller: round-robin between two renderers plus a clear sweep.
// Clear engine is built only when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int                Width      = FB_WIDTH,
  parameter int                AWidth     = FB_AWIDTH,
  parameter int                Depth      = FB_DEPTH,
  parameter logic [Width-1:0]  ClearColor = FB_CLEAR_COLOR
) (
  input  logic              Clock_50,
  input  logic              Reset_n,
  input  logic              ClearReq,
  input  logic              Req0,
  input  logic [AWidth-1:0] Addr0,
  input  logic [Width-1:0]  Data0,
  output logic              Gnt0,
  input  logic              Req1,
  input  logic [AWidth-1:0] Addr1,
  input  logic [Width-1:0]  Data1,
  output logic              Gnt1,
  output logic [AWidth-1:0] WAddress,
  output logic [Width-1:0]  WData,
  output logic              WE,
  output logic              ClearBusy,
  output logic              ClearDone
);

  localparam logic [AWidth-1:0] LastAddr = AWidth'(Depth - 1);

  logic              arb_en;
  logic              we_q, we_d;
  logic [AWidth-1:0] waddr_q, waddr_d;
  logic [Width-1:0]  wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef FB_ARB_CLEAR_EN
  fb_state_e         state_q, state_d;
  logic [AWidth-1:0] cnt_q, cnt_d;

  assign arb_en = Reset_n & (state_q == IDLE) & ~ClearReq;
`else
  logic unused_cfg;

  assign arb_en     = Reset_n;
  assign unused_cfg = ClearReq ^ (|ClearColor) ^ (|LastAddr);
`endif

  rr_arb2 u_rr_arb2 (
    .Clock_50 (Clock_50),
    .Reset_n  (Reset_n),
    .Enable   (arb_en),
    .Req0     (Req0),
    .Req1     (Req1),
    .Gnt0     (Gnt0),
    .Gnt1     (Gnt1)
  );

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef FB_ARB_CLEAR_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      we_d    = 1'b1;
      waddr_d = cnt_q;
      wdata_d = ClearColor;
      if (cnt_q == LastAddr) begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
    end else if (ClearReq) begin
      state_d = CLEAR;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
`endif
    // Grants are already suppressed while clearing, so these never collide with clear writes
    if (Gnt0) begin
      we_d    = 1'b1;
      waddr_d = Addr0;
      wdata_d = Data0;
    end else if (Gnt1) begin
      we_d    = 1'b1;
      waddr_d = Addr1;
      wdata_d = Data1;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (!Reset_n) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FB_ARB_CLEAR_EN
      state_q <= IDLE;
      cnt_q   <= '0;
`endif
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FB_ARB_CLEAR_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign WE        = we_q;
  assign WAddress  = waddr_q;
  assign WData     = wdata_q;
  assign ClearBusy = busy_q;
  assign ClearDone = done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, randomized model check, clear corner cases.
// Clear-engine sequences run only when FB_ARB_CLEAR_EN is defined.
module tb_fb_write_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 3;
  localparam int DEPTH = 32768;
  localparam logic [DW-1:0] CCOL = 3'b010;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          we, busy, done;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  fb_write_arbiter #(
    .Width      (DW),
    .AWidth     (AW),
    .Depth      (DEPTH),
    .ClearColor (CCOL)
  ) dut (
    .Clock_50  (clk),
    .Reset_n   (rst_n),
    .ClearReq  (clear_req),
    .Req0      (req0),
    .Addr0     (addr0),
    .Data0     (data0),
    .Gnt0      (gnt0),
    .Req1      (req1),
    .Addr1     (addr1),
    .Data1     (data1),
    .Gnt1      (gnt1),
    .WAddress  (waddr),
    .WData     (wdata),
    .WE        (we),
    .ClearBusy (busy),
    .ClearDone (done)
  );

  typedef struct {
    logic          r0, r1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g0, g1, ewe;
    logic [AW-1:0] ewa;
    logic [DW-1:0] ewd;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    data0 = '0; data1 = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one full sweep from the cycle after ClearBusy rose; returns the number of bad cycles.
  task automatic sweep(output int errs);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) errs++;
      tick();
      if (we !== 1'b1 || waddr !== AW'(i) || wdata !== CCOL) errs++;
      if (done !== (i == DEPTH - 1)) errs++;
      if (busy !== (i != DEPTH - 1)) errs++;
    end
  endtask

  int  who;
  int  m_last;
  int  errs;
  bit  found;

  initial begin
    vt[0] = '{1'b1, 1'b0, 15'h0010, 15'h0000, 3'b101, 3'b000, 1'b1, 1'b0, 1'b1, 15'h0010, 3'b101};
    vt[1] = '{1'b1, 1'b1, 15'h0100, 15'h0200, 3'b001, 3'b110, 1'b0, 1'b1, 1'b1, 15'h0200, 3'b110};
    vt[2] = '{1'b1, 1'b1, 15'h0100, 15'h0200, 3'b001, 3'b110, 1'b1, 1'b0, 1'b1, 15'h0100, 3'b001};
    vt[3] = '{1'b1, 1'b1, 15'h0100, 15'h0200, 3'b001, 3'b110, 1'b0, 1'b1, 1'b1, 15'h0200, 3'b110};
    vt[4] = '{1'b0, 1'b0, 15'h0100, 15'h0200, 3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 15'h0000, 3'b000};
    vt[5] = '{1'b0, 1'b1, 15'h0000, 15'h7FFF, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 15'h7FFF, 3'b111};
    vt[6] = '{1'b0, 1'b1, 15'h0000, 15'h0001, 3'b000, 3'b011, 1'b0, 1'b1, 1'b1, 15'h0001, 3'b011};
    vt[7] = '{1'b1, 1'b1, 15'h7FFE, 15'h0001, 3'b010, 3'b011, 1'b1, 1'b0, 1'b1, 15'h7FFE, 3'b010};
    vt[8] = '{1'b1, 1'b0, 15'h0000, 15'h0001, 3'b000, 3'b011, 1'b1, 1'b0, 1'b1, 15'h0000, 3'b000};
    vt[9] = '{1'b1, 1'b1, 15'h0000, 15'h1111, 3'b000, 3'b100, 1'b0, 1'b1, 1'b1, 15'h1111, 3'b100};

    // Reset held three cycles with a pending request
    idle_inputs();
    rst_n = 1'b0;
    req0  = 1'b1;
    addr0 = 15'h0010;
    data0 = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_gnt0", gnt0, 0);
      tick();
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_done", done, 0);
    end
    rst_n = 1'b1;
    req0  = 1'b0;
    tick();

    // Vector table starting from a fresh pointer favouring requester 0
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1;
      addr0 = vt[i].a0; addr1 = vt[i].a1;
      data0 = vt[i].d0; data1 = vt[i].d1;
      #1;
      chk($sformatf("vec%0d_gnt0", i), gnt0, vt[i].g0);
      chk($sformatf("vec%0d_gnt1", i), gnt1, vt[i].g1);
      tick();
      chk($sformatf("vec%0d_we", i), we, vt[i].ewe);
      if (vt[i].ewe) begin
        chk($sformatf("vec%0d_waddr", i), waddr, vt[i].ewa);
        chk($sformatf("vec%0d_wdata", i), wdata, vt[i].ewd);
      end
    end

    // Continuous contention straight out of reset alternates 0,1,0,1
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 15'h0AAA; addr1 = 15'h0555;
    data0 = 3'b001;   data1 = 3'b110;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_gnt0", gnt0, (i % 2 == 0));
      chk("cont_gnt1", gnt1, (i % 2 == 1));
      tick();
      chk("cont_we", we, 1);
      chk("cont_waddr", waddr, (i % 2 == 0) ? 15'h0AAA : 15'h0555);
    end

    // Randomized traffic against a fairness model
    do_reset();
    m_last = 1;
    for (int i = 0; i < 400; i++) begin
      req0  = 1'($urandom_range(0, 1));
      req1  = 1'($urandom_range(0, 1));
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      data0 = DW'($urandom);
      data1 = DW'($urandom);
`ifdef FB_ARB_CLEAR_EN
      clear_req = 1'b0;
`else
      clear_req = 1'($urandom_range(0, 1));
`endif
      #1;
      if (req0 && req1)  who = (m_last == 0) ? 1 : 0;
      else if (req0)     who = 0;
      else if (req1)     who = 1;
      else               who = -1;
      chk("rand_gnt0", gnt0, (who == 0));
      chk("rand_gnt1", gnt1, (who == 1));
      tick();
      chk("rand_we", we, (who >= 0));
      chk("rand_busy", busy, 0);
      if (who == 0) begin
        chk("rand_waddr", waddr, addr0);
        chk("rand_wdata", wdata, data0);
      end else if (who == 1) begin
        chk("rand_waddr", waddr, addr1);
        chk("rand_wdata", wdata, data1);
      end
      if (who >= 0) m_last = who;
    end
    idle_inputs();

`ifdef FB_ARB_CLEAR_EN
    // Clear with requester 1 waiting
    do_reset();
    req1 = 1'b1; addr1 = 15'h0555; data1 = 3'b100;
    clear_req = 1'b1;
    #1;
    chk("clr1_gnt1_req_cycle", gnt1, 0);
    tick();
    clear_req = 1'b0;
    chk("clr1_busy_rise", busy, 1);
    chk("clr1_we_first", we, 0);
    sweep(errs);
    chk("clr1_sweep_errs", errs, 0);
    chk("clr1_done_last", done, 1);
    chk("clr1_last_addr", waddr, 15'h7FFF);
    chk("clr1_gnt1_after", gnt1, 1);
    tick();
    chk("clr1_done_pulse", done, 0);
    chk("clr1_req_we", we, 1);
    chk("clr1_req_waddr", waddr, 15'h0555);
    chk("clr1_req_wdata", wdata, 3'b100);
    idle_inputs();

    // ClearReq and Req0 in the same cycle: clear wins, Req0 served afterwards
    do_reset();
    req0 = 1'b1; addr0 = 15'h0ABC; data0 = 3'b011;
    clear_req = 1'b1;
    #1;
    chk("clr2_gnt0_req_cycle", gnt0, 0);
    tick();
    clear_req = 1'b0;
    chk("clr2_busy_rise", busy, 1);
    chk("clr2_we_first", we, 0);
    sweep(errs);
    chk("clr2_sweep_errs", errs, 0);
    chk("clr2_gnt0_after", gnt0, 1);
    tick();
    chk("clr2_req_we", we, 1);
    chk("clr2_req_waddr", waddr, 15'h0ABC);
    chk("clr2_req_wdata", wdata, 3'b011);
    idle_inputs();

    // Reset in the middle of a clear abandons it
    do_reset();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 15'h1234 + 4; i++) begin
      tick();
      if (we === 1'b1 && waddr === 15'h1234) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_reached_1234", found, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_we", we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    addr0 = 15'h0321; addr1 = 15'h0654;
    #1;
    chk("mid_gnt0", gnt0, 1);
    chk("mid_gnt1", gnt1, 0);
    tick();
    chk("mid_waddr0", waddr, 15'h0321);
    chk("mid_no_done", done, 0);
    chk("mid_gnt1_next", gnt1, 1);
    tick();
    chk("mid_waddr1", waddr, 15'h0654);
    chk("mid_busy_after", busy, 0);
    idle_inputs();
`else
    // Without the clear engine ClearReq must not gate grants
    do_reset();
    clear_req = 1'b1;
    req0 = 1'b1; addr0 = 15'h0321; data0 = 3'b110;
    #1;
    chk("noclr_gnt0", gnt0, 1);
    tick();
    clear_req = 1'b0;
    req0 = 1'b0;
    chk("noclr_we", we, 1);
    chk("noclr_waddr", waddr, 15'h0321);
    chk("noclr_busy", busy, 0);
    tick();
    chk("noclr_busy2", busy, 0);
    chk("noclr_done", done, 0);
    chk("noclr_we_idle", we, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-port controller for the 32K x 3-bit dual-port frame buffer RAM. Shares the single 50 MHz write port between two pixel producers (e.g. staff renderer and note renderer) using round-robin arbitration. Contains a clear engine that sweeps every address with a background colour on request. Sits between the renderers and the RAM write side; the 25 MHz read side is untouched.

## Interface
Parameters:
- Width, 3, pixel data width (RGB bits)
- AWidth, 15, address width
- Depth, 32768, number of addressable pixels; clear sweeps 0..Depth-1
- ClearColor, 3'b000, value written by the clear engine

Ports:
- Clock_50  in  1  sole clock, rising edge
- Reset_n  in  1  reset; synchronous, active-low
- ClearReq  in  1  start clear; sampled only in IDLE
- Req0  in  1  requester 0 has a pixel to write
- Addr0  in  AWidth  requester 0 address; stable while Req0 high
- Data0  in  Width  requester 0 pixel
- Gnt0  out  1  combinational accept; transfer on edge with Req0 & Gnt0
- Req1, Addr1, Data1, Gnt1: same for requester 1
- WAddress  out  AWidth  registered RAM write address
- WData  out  Width  registered RAM write data
- WE  out  1  registered RAM write enable
- ClearBusy  out  1  registered; high while clear sweep runs
- ClearDone  out  1  registered one-cycle pulse on final clear write

## Operation
- States: IDLE, CLEAR. Reset → IDLE, clear counter 0, round-robin pointer favours requester 0.
- IDLE, ClearReq=1: Gnt0=Gnt1=0 that cycle, next state CLEAR, counter 0. ClearReq has priority over same-cycle requests.
- IDLE, ClearReq=0: the sole requester is granted. If both request, the one not granted last wins. The pointer updates only on a transfer.
- CLEAR: Gnt0=Gnt1=0. One write per cycle, address = counter, data = ClearColor. Counter increments until Depth-1, then IDLE. ClearReq is ignored in CLEAR.
- The counter is AWidth bits. The terminal compare is against Depth-1, so non-power-of-2 Depth stops early with no wrap.
- Requests are held, not dropped, during CLEAR. They are serviced in the cycle after ClearBusy falls.
- Reset at any point, including mid-clear: next cycle WE=0, ClearBusy=0, ClearDone=0, state IDLE. The partial clear is abandoned and not resumed.

## Timing
- Reset values: WE=0, WAddress=0, WData=0, ClearBusy=0, ClearDone=0. Gnt0/Gnt1 follow combinationally (0 unless requesting).
- Requester write latency: transfer at edge k → WE=1 with WAddress/WData in the cycle after edge k (1 cycle).
- WE is low in any cycle following an edge with no transfer and no clear write.
- Clear, ClearReq sampled at edge k:
  - ClearBusy=1 after edge k.
  - Writes to addresses 0..Depth-1 appear after edges k+1..k+Depth.
  - After edge k+Depth: ClearDone=1 and ClearBusy=0, coincident with the final write.
- Clear duration is Depth+1 cycles (≈655 µs at 50 MHz for 32768).
- Throughput is one write per cycle sustained, in both requester and clear modes.

## Configuration
- FB_ARB_CLEAR_EN defined: clear engine, CLEAR state and counter are present as above.
- FB_ARB_CLEAR_EN undefined:
  - No CLEAR state. ClearReq is ignored and does not gate grants.
  - ClearBusy and ClearDone are tied 0. ClearColor is unused.
  - Arbiter behaviour is otherwise identical.

## Structure
- Shared package fb_pkg holds:
  - FB_AWIDTH=15, FB_WIDTH=3, FB_DEPTH=32768;
  - the state typedef {IDLE, CLEAR};
  - the background colour constant. Shared with the RAM instantiation and renderers.
- One sub-module: rr_arb2.
  - Two-input round-robin arbiter: Req0/Req1/Enable in, Gnt0/Gnt1 out, last-winner pointer register.
  - Reused by any future two-requester frame buffer client.

## Test plan
- Reset: hold Reset_n=0 three cycles with Req0=1 → WE=0, Gnt0=0, ClearBusy=0, WAddress=0 throughout.
- Single requester: Req0=1, Addr0=15'h0010, Data0=3'b101 → Gnt0=1 the same cycle; next cycle WE=1, WAddress=15'h0010, WData=3'b101.
- Contention: Req0=Req1=1 continuously after reset → grants alternate 0,1,0,1. WAddress alternates Addr0/Addr1 with WE=1 every cycle.
- Clear (ClearColor=3'b010): ClearReq pulse with Req1 held high →
  - ClearBusy rises; 32768 consecutive writes to 0..15'h7FFF with WData=3'b010; Gnt1=0 throughout.
  - ClearDone is a one-cycle pulse with the 15'h7FFF write; Gnt1=1 the next cycle.
- Simultaneous ClearReq and Req0 in IDLE → Gnt0=0 that cycle. Clear runs first; Req0 is written after ClearDone.
- Reset mid-clear at WAddress=15'h1234 → next cycle WE=0, ClearBusy=0, no ClearDone. After release, Req0/Req1 contention grants requester 0 first.
